// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB with ack-handshaked fetch and data ports.
// Define BRANCH_EXT_EN to add BNE/BLT/BGE/BLTU/BGEU; without it those opcodes trap to ERROR.
module multicycle_core #(
   parameter logic [31:0] INITIAL_PC   = 32'h0040_0000,
   parameter int unsigned MEM_WAIT_MAX = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        iReq,
   output logic [31:0] iAddr,
   input  logic [31:0] iRdata,
   input  logic        iAck,
   output logic        dReq,
   output logic        dWe,
   output logic [31:0] dAddr,
   output logic [31:0] dWdata,
   input  logic [31:0] dRdata,
   input  logic        dAck,
   output logic [31:0] PC,
   output logic [2:0]  state,
   output logic        retire,
   output logic        err
);
   typedef enum logic [2:0] {
      FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, ERROR = 3'd5
   } state_t;

   localparam logic [6:0]  OPC_OP   = 7'h33;
   localparam logic [6:0]  OPC_OPI  = 7'h13;
   localparam logic [6:0]  OPC_LW   = 7'h03;
   localparam logic [6:0]  OPC_SW   = 7'h23;
   localparam logic [6:0]  OPC_BR   = 7'h63;
   localparam logic [16:0] WAIT_LIM = 17'(MEM_WAIT_MAX);

   state_t      st;
   logic [31:0] pc_q, ir, a_q, b_q, imm_q, alu_out, mdr;
   logic [31:0] xr [32];
   logic [15:0] wait_cnt;

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [4:0]  rs1, rs2, rd, shamt;
   logic        is_op, is_opi, is_lw, is_sw, is_br, legal, br_take, timeout;
   logic [31:0] imm_i, imm_s, imm_b, opb, alu_y, br_tgt;

   assign opc = ir[6:0];
   assign rd  = ir[11:7];
   assign f3  = ir[14:12];
   assign rs1 = ir[19:15];
   assign rs2 = ir[24:20];
   assign f7  = ir[31:25];

   assign imm_i = {{20{ir[31]}}, ir[31:20]};
   assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

   // SLTU/SLTIU are outside the supported subset, hence the f3 != 3 exclusions.
   assign is_op  = (opc == OPC_OP) && (f3 != 3'd3) &&
                   ((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
   assign is_opi = (opc == OPC_OPI) && (f3 != 3'd3) &&
                   ((f3 == 3'd1) ? (f7 == 7'h00) :
                    (f3 == 3'd5) ? ((f7 == 7'h00) || (f7 == 7'h20)) : 1'b1);
   assign is_lw  = (opc == OPC_LW) && (f3 == 3'd2);
   assign is_sw  = (opc == OPC_SW) && (f3 == 3'd2);
`ifdef BRANCH_EXT_EN
   assign is_br  = (opc == OPC_BR) && (f3 != 3'd2) && (f3 != 3'd3);
`else
   assign is_br  = (opc == OPC_BR) && (f3 == 3'd0);
`endif
   assign legal  = is_op | is_opi | is_lw | is_sw | is_br;

   assign opb    = is_op ? b_q : imm_q;
   assign shamt  = opb[4:0];
   assign br_tgt = pc_q + imm_q;

   always_comb begin
      alu_y = a_q + opb;
      if (is_op || is_opi) begin
         case (f3)
            3'd0:    alu_y = (is_op && f7[5]) ? a_q - opb : a_q + opb;
            3'd1:    alu_y = a_q << shamt;
            3'd2:    alu_y = {31'd0, ($signed(a_q) < $signed(opb))};
            3'd4:    alu_y = a_q ^ opb;
            3'd5:    alu_y = f7[5] ? $unsigned($signed(a_q) >>> shamt) : a_q >> shamt;
            3'd6:    alu_y = a_q | opb;
            3'd7:    alu_y = a_q & opb;
            default: alu_y = a_q + opb;
         endcase
      end
   end

   always_comb begin
      case (f3)
         3'd0:    br_take = (a_q == b_q);
`ifdef BRANCH_EXT_EN
         3'd1:    br_take = (a_q != b_q);
         3'd4:    br_take = ($signed(a_q) <  $signed(b_q));
         3'd5:    br_take = ($signed(a_q) >= $signed(b_q));
         3'd6:    br_take = (a_q <  b_q);
         3'd7:    br_take = (a_q >= b_q);
`endif
         default: br_take = 1'b0;
      endcase
   end

   // Fires on the unacked cycle that would bring the count up to the limit.
   assign timeout = (WAIT_LIM != 17'd0) && (({1'b0, wait_cnt} + 17'd1) == WAIT_LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= FETCH;
         pc_q     <= INITIAL_PC;
         ir       <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         alu_out  <= '0;
         mdr      <= '0;
         wait_cnt <= '0;
         retire   <= 1'b0;
         for (int i = 0; i < 32; i++) xr[i] <= '0;
      end else begin
         retire <= 1'b0;
         case (st)
            FETCH: begin
               if (iAck) begin
                  ir <= iRdata;
                  st <= DECODE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
                  if (timeout) st <= ERROR;
               end
            end
            DECODE: begin
               a_q   <= (rs1 == 5'd0) ? 32'd0 : xr[rs1];
               b_q   <= (rs2 == 5'd0) ? 32'd0 : xr[rs2];
               imm_q <= is_sw ? imm_s : (opc == OPC_BR) ? imm_b : imm_i;
               st    <= legal ? EXEC : ERROR;
            end
            EXEC: begin
               alu_out <= alu_y;
               if (is_br) begin
                  if (br_take && (br_tgt[1:0] != 2'b00)) begin
                     st <= ERROR;
                  end else begin
                     pc_q     <= br_take ? br_tgt : pc_q + 32'd4;
                     retire   <= 1'b1;
                     wait_cnt <= '0;
                     st       <= FETCH;
                  end
               end else if (is_lw || is_sw) begin
                  if (alu_y[1:0] != 2'b00) begin
                     st <= ERROR;
                  end else begin
                     wait_cnt <= '0;
                     st       <= MEM;
                  end
               end else begin
                  st <= WB;
               end
            end
            MEM: begin
               if (dAck) begin
                  if (is_lw) begin
                     mdr <= dRdata;
                     st  <= WB;
                  end else begin
                     pc_q     <= pc_q + 32'd4;
                     retire   <= 1'b1;
                     wait_cnt <= '0;
                     st       <= FETCH;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
                  if (timeout) st <= ERROR;
               end
            end
            WB: begin
               if (rd != 5'd0) xr[rd] <= is_lw ? mdr : alu_out;
               pc_q     <= pc_q + 32'd4;
               retire   <= 1'b1;
               wait_cnt <= '0;
               st       <= FETCH;
            end
            default: st <= ERROR;
         endcase
      end
   end

   assign state  = st;
   assign PC     = pc_q;
   assign err    = (st == ERROR);
   assign iReq   = (st == FETCH) && !rst;
   assign iAddr  = pc_q;
   assign dReq   = (st == MEM);
   assign dWe    = (st == MEM) && is_sw;
   assign dAddr  = alu_out;
   assign dWdata = b_q;
endmodule
